// File: rtl/wb_branch_unit.sv
// Writeback / branch-resolve stage at the tail of the EX delay line.
// Registers regfile write data and HI/LO, and turns taken branches into a one-cycle PC redirect plus a wrong-path flush.
module wb_branch_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int IM_ADDR_WIDTH  = 16,
  parameter int FLUSH_CYCLES   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      regwrite_i,
  input  logic                      regwriteui_i,
  input  logic [1:0]                regwritehilo_i,
  input  logic                      sr_i,
  input  logic                      cmpsel_i,
  input  logic                      branchen_i,
  input  logic [2:0]                branchtype_i,
  input  logic [IM_ADDR_WIDTH-1:0]  branchtarget_i,
  input  logic [36:0]               p_i,
  input  logic [3:0]                dm_re_i,
  input  logic [DATA_WIDTH-1:0]     dm_regfile_data_i,
  output logic                      wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]     wr_data_o,
  output logic [DATA_WIDTH-1:0]     hi_o,
  output logic [DATA_WIDTH-1:0]     lo_o,
  output logic                      redirect_o,
  output logic [IM_ADDR_WIDTH-1:0]  redirect_pc_o,
  output logic                      flush_o
);

  localparam logic [0:0] IDLE       = 1'b0;
  localparam logic [0:0] FLUSH      = 1'b1;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  logic [0:0] state;
  logic [3:0] flush_cnt;

  function automatic logic [DATA_WIDTH-1:0] load_sel(input logic [3:0] re,
                                                     input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    r = w;
    case (re)
      4'b0011: r = DATA_WIDTH'(w[15:0]);
      4'b1100: r = DATA_WIDTH'(w[31:16]);
      4'b0001: r = DATA_WIDTH'(w[7:0]);
      4'b0010: r = DATA_WIDTH'(w[15:8]);
      4'b0100: r = DATA_WIDTH'(w[23:16]);
      4'b1000: r = DATA_WIDTH'(w[31:24]);
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sext_hi(input logic signed [4:0] v);
    logic signed [DATA_WIDTH-1:0] e;
    e = DATA_WIDTH'(v);
    return e;
  endfunction

  function automatic logic branch_cond(input logic [2:0] bt, input logic z, input logic n);
    logic c;
    c = 1'b0;
    case (bt)
      3'b000:  c = z;
      3'b001:  c = !z;
      3'b010:  c = n;
      3'b011:  c = !n;
      3'b100:  c = !n && !z;
      3'b101:  c = n || z;
      3'b110:  c = 1'b1;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // Stage p0: slot qualification, writeback select and branch resolution
  logic                  vld_p0;
  logic                  taken_p0;
  logic [DATA_WIDTH-1:0] wb_data_p0;

  always_comb begin
    vld_p0   = (state != FLUSH);
    taken_p0 = branchen_i && vld_p0 &&
               branch_cond(branchtype_i, (p_i[31:0] == 32'd0), p_i[36]);
    if (dm_re_i != 4'd0)
      wb_data_p0 = load_sel(dm_re_i, dm_regfile_data_i);
    else if (regwriteui_i)
      wb_data_p0 = DATA_WIDTH'({p_i[15:0], 16'h0000});
    else if (cmpsel_i)
      wb_data_p0 = DATA_WIDTH'(p_i[36]);
    else if (sr_i)
      wb_data_p0 = DATA_WIDTH'(p_i[36:5]);
    else
      wb_data_p0 = DATA_WIDTH'(p_i[31:0]);
  end

  // Stage p1: registered writeback, HI/LO, redirect and flush control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_o       <= 1'b0;
      wr_addr_o     <= '0;
      wr_data_o     <= '0;
      hi_o          <= '0;
      lo_o          <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      state         <= IDLE;
      flush_cnt     <= 4'd0;
    end else begin
      wr_en_o    <= regwrite_i && vld_p0;
      wr_addr_o  <= rd_addr_i;
      wr_data_o  <= wb_data_p0;
      redirect_o <= taken_p0;
      if (vld_p0 && regwritehilo_i[0]) lo_o <= DATA_WIDTH'(p_i[31:0]);
      if (vld_p0 && regwritehilo_i[1]) hi_o <= sext_hi(p_i[36:32]);
      if (taken_p0) redirect_pc_o <= branchtarget_i;
      case (state)
        IDLE: begin
          if (taken_p0 && (FLUSH_LOAD != 4'd0)) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end
        end
        default: begin
          // Branches seen here are wrong-path and never reload the counter.
          if (flush_cnt <= 4'd1) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
      endcase
    end
  end

  assign flush_o = (state == FLUSH);

endmodule

// File: tb/tb_wb_branch_unit.sv
// Directed bench for wb_branch_unit: a vector table for the single-slot datapath
// plus hand-written branch/flush/reset sequences (second instance has no flush window).
module tb_wb_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr;
  logic        regwrite, regwriteui, sr, cmpsel, branchen;
  logic [1:0]  regwritehilo;
  logic [2:0]  branchtype;
  logic [15:0] branchtarget;
  logic [36:0] p;
  logic [3:0]  dm_re;
  logic [31:0] dm_data;

  logic        wr_en, redirect, flush;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, hi, lo;
  logic [15:0] redirect_pc;

  logic        nf_wr_en, nf_redirect, nf_flush;
  logic [4:0]  nf_wr_addr;
  logic [31:0] nf_wr_data, nf_hi, nf_lo;
  logic [15:0] nf_redirect_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_branch_unit #(.FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .regwrite_i(regwrite),
    .regwriteui_i(regwriteui), .regwritehilo_i(regwritehilo), .sr_i(sr),
    .cmpsel_i(cmpsel), .branchen_i(branchen), .branchtype_i(branchtype),
    .branchtarget_i(branchtarget), .p_i(p), .dm_re_i(dm_re),
    .dm_regfile_data_i(dm_data), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .hi_o(hi), .lo_o(lo), .redirect_o(redirect),
    .redirect_pc_o(redirect_pc), .flush_o(flush)
  );

  wb_branch_unit #(.FLUSH_CYCLES(0)) u_nf (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .regwrite_i(regwrite),
    .regwriteui_i(regwriteui), .regwritehilo_i(regwritehilo), .sr_i(sr),
    .cmpsel_i(cmpsel), .branchen_i(branchen), .branchtype_i(branchtype),
    .branchtarget_i(branchtarget), .p_i(p), .dm_re_i(dm_re),
    .dm_regfile_data_i(dm_data), .wr_en_o(nf_wr_en), .wr_addr_o(nf_wr_addr),
    .wr_data_o(nf_wr_data), .hi_o(nf_hi), .lo_o(nf_lo), .redirect_o(nf_redirect),
    .redirect_pc_o(nf_redirect_pc), .flush_o(nf_flush)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic        ui;
    logic [1:0]  hilo;
    logic        sr;
    logic        cmp;
    logic        ben;
    logic [2:0]  bt;
    logic [36:0] p;
    logic [3:0]  re;
    logic        exp_en;
    logic [31:0] exp_data;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rw_, input logic [4:0] rd_, input logic ui_,
                     input logic [1:0] hilo_, input logic sr_, input logic cmp_,
                     input logic ben_, input logic [2:0] bt_, input logic [36:0] p_,
                     input logic [3:0] re_, input logic en_, input logic [31:0] d_,
                     input logic [31:0] hi_, input logic [31:0] lo_);
    vec_t v;
    v.rw = rw_; v.rd = rd_; v.ui = ui_; v.hilo = hilo_; v.sr = sr_; v.cmp = cmp_;
    v.ben = ben_; v.bt = bt_; v.p = p_; v.re = re_;
    v.exp_en = en_; v.exp_data = d_; v.exp_hi = hi_; v.exp_lo = lo_;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    rd_addr = 5'd0; regwrite = 1'b0; regwriteui = 1'b0; regwritehilo = 2'b00;
    sr = 1'b0; cmpsel = 1'b0; branchen = 1'b0; branchtype = 3'b000;
    branchtarget = 16'h0000; p = 37'h0; dm_re = 4'h0; dm_data = 32'hAABBCCDD;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_branch(input logic [2:0] bt, input logic [36:0] pv,
                              input logic [15:0] tgt);
    idle_in();
    branchen = 1'b1; branchtype = bt; p = pv; branchtarget = tgt;
  endtask

  initial begin
    logic [2:0]  tk_bt [6];
    logic [36:0] tk_p  [6];

    idle_in();
    rst = 1'b0;
    step(); step();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_flush", flush, 0);
    rst = 1'b1;

    // rw rd ui hilo sr cmp ben bt p re | en data hi lo
    add(1, 7, 0, 2'b00, 0, 0, 0, 3'b000, 37'h0_1234_5678, 4'b0000, 1, 32'h12345678, 0, 0);
    add(1, 3, 0, 2'b00, 0, 0, 0, 3'b000, 37'h0, 4'b0100, 1, 32'h000000BB, 0, 0);
    add(1, 3, 0, 2'b00, 0, 0, 0, 3'b000, 37'h0, 4'b1100, 1, 32'h0000AABB, 0, 0);
    add(1, 3, 0, 2'b00, 0, 0, 0, 3'b000, 37'h0, 4'b1111, 1, 32'hAABBCCDD, 0, 0);
    add(1, 3, 0, 2'b00, 0, 0, 0, 3'b000, 37'h0, 4'b0001, 1, 32'h000000DD, 0, 0);
    add(1, 3, 0, 2'b00, 0, 0, 0, 3'b000, 37'h0, 4'b0010, 1, 32'h000000CC, 0, 0);
    add(1, 3, 0, 2'b00, 0, 0, 0, 3'b000, 37'h0, 4'b1000, 1, 32'h000000AA, 0, 0);
    add(1, 3, 0, 2'b00, 0, 0, 0, 3'b000, 37'h0, 4'b0011, 1, 32'h0000CCDD, 0, 0);
    add(1, 3, 0, 2'b00, 0, 0, 0, 3'b000, 37'h0, 4'b0101, 1, 32'hAABBCCDD, 0, 0);
    add(1, 4, 1, 2'b00, 0, 0, 0, 3'b000, 37'h0_0000_BEEF, 4'b0001, 1, 32'h000000DD, 0, 0);
    add(1, 4, 1, 2'b00, 0, 0, 0, 3'b000, 37'h0_0000_BEEF, 4'b0000, 1, 32'hBEEF0000, 0, 0);
    add(1, 5, 1, 2'b00, 0, 1, 0, 3'b000, 37'h10_0000_BEEF, 4'b0000, 1, 32'hBEEF0000, 0, 0);
    add(1, 5, 0, 2'b00, 0, 1, 0, 3'b000, 37'h10_0000_0000, 4'b0000, 1, 32'h00000001, 0, 0);
    add(1, 6, 0, 2'b00, 1, 1, 0, 3'b000, 37'h00_0000_0100, 4'b0000, 1, 32'h00000000, 0, 0);
    add(1, 6, 0, 2'b00, 1, 0, 0, 3'b000, 37'h00_0000_0100, 4'b0000, 1, 32'h00000008, 0, 0);
    add(1, 6, 0, 2'b00, 1, 0, 0, 3'b000, 37'h10_0000_0000, 4'b0000, 1, 32'h80000000, 0, 0);
    add(0, 1, 0, 2'b11, 0, 0, 0, 3'b000, 37'h1F_0000_0010, 4'b0000, 0, 32'h0, 32'hFFFFFFFF, 32'h10);
    add(0, 1, 0, 2'b01, 0, 0, 0, 3'b000, 37'h00_0000_0077, 4'b0000, 0, 32'h0, 32'hFFFFFFFF, 32'h77);
    add(0, 1, 0, 2'b10, 0, 0, 0, 3'b000, 37'h05_0000_0000, 4'b0000, 0, 32'h0, 32'h5, 32'h77);
    add(1, 0, 0, 2'b00, 0, 0, 0, 3'b000, 37'h00_0000_00AB, 4'b0000, 1, 32'h000000AB, 32'h5, 32'h77);
    add(0, 0, 0, 2'b00, 0, 0, 1, 3'b000, 37'h00_0000_0005, 4'b0000, 0, 32'h0, 32'h5, 32'h77);
    add(0, 0, 0, 2'b00, 0, 0, 1, 3'b111, 37'h00_0000_0000, 4'b0000, 0, 32'h0, 32'h5, 32'h77);
    add(0, 0, 0, 2'b00, 0, 0, 1, 3'b001, 37'h00_0000_0000, 4'b0000, 0, 32'h0, 32'h5, 32'h77);
    add(0, 0, 0, 2'b00, 0, 0, 1, 3'b010, 37'h00_0000_0001, 4'b0000, 0, 32'h0, 32'h5, 32'h77);
    add(0, 0, 0, 2'b00, 0, 0, 1, 3'b100, 37'h00_0000_0000, 4'b0000, 0, 32'h0, 32'h5, 32'h77);
    add(0, 0, 0, 2'b00, 0, 0, 1, 3'b011, 37'h10_0000_0001, 4'b0000, 0, 32'h0, 32'h5, 32'h77);
    add(0, 0, 0, 2'b00, 0, 0, 1, 3'b101, 37'h00_0000_0001, 4'b0000, 0, 32'h0, 32'h5, 32'h77);

    for (int i = 0; i < vq.size(); i++) begin
      idle_in();
      regwrite = vq[i].rw; rd_addr = vq[i].rd; regwriteui = vq[i].ui;
      regwritehilo = vq[i].hilo; sr = vq[i].sr; cmpsel = vq[i].cmp;
      branchen = vq[i].ben; branchtype = vq[i].bt; p = vq[i].p; dm_re = vq[i].re;
      branchtarget = 16'h0BAD;
      step();
      chk($sformatf("v%0d_wr_en", i), wr_en, vq[i].exp_en);
      if (vq[i].exp_en) begin
        chk($sformatf("v%0d_wr_addr", i), wr_addr, vq[i].rd);
        chk($sformatf("v%0d_wr_data", i), wr_data, vq[i].exp_data);
      end
      chk($sformatf("v%0d_hi", i), hi, vq[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo, vq[i].exp_lo);
      chk($sformatf("v%0d_redirect", i), redirect, 0);
      chk($sformatf("v%0d_flush", i), flush, 0);
    end
    chk("not_taken_pc_held", redirect_pc, 0);

    // BNE taken, then four write slots: three squashed, the fourth commits.
    drive_branch(3'b001, 37'h5, 16'h0040);
    step();
    chk("bne_redirect", redirect, 1);
    chk("bne_pc", redirect_pc, 16'h0040);
    chk("bne_flush", flush, 1);
    chk("bne_wr_en", wr_en, 0);
    for (int s = 1; s <= 4; s++) begin
      idle_in();
      regwrite = 1'b1; rd_addr = 5'd9; p = 37'(s);
      if (s <= 2) begin
        branchen = 1'b1; branchtype = 3'b110; branchtarget = 16'h0080;
      end
      step();
      chk($sformatf("fl%0d_redirect", s), redirect, 0);
      chk($sformatf("fl%0d_pc", s), redirect_pc, 16'h0040);
      chk($sformatf("fl%0d_flush", s), flush, (s <= 2) ? 1 : 0);
      chk($sformatf("fl%0d_wr_en", s), wr_en, (s == 4) ? 1 : 0);
    end
    chk("fl4_wr_data", wr_data, 32'h4);
    chk("fl4_hi_kept", hi, 32'h5);

    // Every taking condition code, each followed by its three-slot flush.
    tk_bt[0] = 3'b000; tk_p[0] = 37'h0;
    tk_bt[1] = 3'b001; tk_p[1] = 37'h5;
    tk_bt[2] = 3'b010; tk_p[2] = 37'h10_0000_0000;
    tk_bt[3] = 3'b011; tk_p[3] = 37'h1;
    tk_bt[4] = 3'b100; tk_p[4] = 37'h1;
    tk_bt[5] = 3'b101; tk_p[5] = 37'h10_0000_0001;
    for (int k = 0; k < 6; k++) begin
      drive_branch(tk_bt[k], tk_p[k], 16'h1000 + 16'(k));
      step();
      chk($sformatf("tk%0d_redirect", k), redirect, 1);
      chk($sformatf("tk%0d_pc", k), redirect_pc, 16'h1000 + 16'(k));
      idle_in();
      step(); step(); step();
      chk($sformatf("tk%0d_flush_done", k), flush, 0);
    end

    // Link-style: taken branch and write land on the same cycle.
    drive_branch(3'b110, 37'h1234, 16'h0100);
    regwrite = 1'b1; rd_addr = 5'd31;
    step();
    chk("link_wr_en", wr_en, 1);
    chk("link_wr_addr", wr_addr, 31);
    chk("link_wr_data", wr_data, 32'h1234);
    chk("link_redirect", redirect, 1);
    chk("link_pc", redirect_pc, 16'h0100);

    // Asynchronous reset between edges while flushing.
    idle_in();
    #2 rst = 1'b0;
    #1;
    chk("ar_wr_en", wr_en, 0);
    chk("ar_wr_data", wr_data, 0);
    chk("ar_hi", hi, 0);
    chk("ar_lo", lo, 0);
    chk("ar_redirect", redirect, 0);
    chk("ar_pc", redirect_pc, 0);
    chk("ar_flush", flush, 0);
    @(negedge clk);
    rst = 1'b1;
    regwrite = 1'b1; rd_addr = 5'd12; p = 37'h55;
    step();
    chk("ar_first_wr_en", wr_en, 1);
    chk("ar_first_wr_data", wr_data, 32'h55);
    chk("ar_first_flush", flush, 0);

    // No flush window: consecutive taken branches give consecutive pulses.
    drive_branch(3'b110, 37'h0, 16'h0010);
    step();
    chk("nf1_redirect", nf_redirect, 1);
    chk("nf1_pc", nf_redirect_pc, 16'h0010);
    chk("nf1_flush", nf_flush, 0);
    drive_branch(3'b110, 37'h0, 16'h0020);
    regwrite = 1'b1; rd_addr = 5'd2; p = 37'h77;
    step();
    chk("nf2_redirect", nf_redirect, 1);
    chk("nf2_pc", nf_redirect_pc, 16'h0020);
    chk("nf2_wr_en", nf_wr_en, 1);
    chk("nf2_wr_data", nf_wr_data, 32'h77);
    idle_in();
    step();
    chk("nf3_redirect", nf_redirect, 0);
    chk("nf3_pc_held", nf_redirect_pc, 16'h0020);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
